// File: rtl/rf_arb_pkg.sv
// Shared types for the two-client register-file port arbiter.
package rf_arb_pkg;

    localparam int unsigned NUM_CLIENTS = 2;
    localparam int unsigned CNT_W       = 4;

    typedef logic             client_t;
    typedef logic [3:0]       regsel_t;
    typedef logic [15:0]      word_t;
    typedef logic [CNT_W-1:0] lock_cnt_t;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    function automatic client_t other_client(input client_t c);
        return ~c;
    endfunction

endpackage

// File: rtl/rf_rr_lock_sel.sv
// Picks the winning client: a lock owner under its budget first, then round-robin.
module rf_rr_lock_sel
    import rf_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic [1:0]  eligible,
    input  client_t     last_grant,
    input  lock_state_t lock_state,
    input  client_t     lock_owner,
    input  lock_cnt_t   lock_cnt,
    output client_t     g,
    output logic        grant
);

    localparam lock_cnt_t LockMax = lock_cnt_t'(LOCK_MAX);

    logic    owner_wins;
    client_t rr_first;

    assign owner_wins = (lock_state == LOCKED) && eligible[lock_owner] && (lock_cnt < LockMax);
    assign rr_first   = other_client(last_grant);

    always_comb begin
        g     = 1'b0;
        grant = 1'b0;
        if (owner_wins) begin
            g     = lock_owner;
            grant = 1'b1;
        end else if (eligible[rr_first]) begin
            g     = rr_first;
            grant = 1'b1;
        end else if (eligible[last_grant]) begin
            g     = last_grant;
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Grants the 1W/2R register file to one of two clients per cycle and returns
// read data through a one-deep valid/ready response register per client.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_wen,
    input  logic [1:0]       req_lock,
    input  logic [1:0][3:0]  req_wsel,
    input  logic [1:0][3:0]  req_rsel1,
    input  logic [1:0][3:0]  req_rsel2,
    input  logic [1:0][15:0] req_wdat,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0][15:0] rsp_rdat1,
    output logic [1:0][15:0] rsp_rdat2,
    output logic             rf_WEN,
    output logic [3:0]       rf_wsel,
    output logic [3:0]       rf_rsel1,
    output logic [3:0]       rf_rsel2,
    output logic [15:0]      rf_wdat,
    input  logic [15:0]      rf_rdat1,
    input  logic [15:0]      rf_rdat2
);

    localparam lock_cnt_t LockMax = lock_cnt_t'(LOCK_MAX);

    logic [1:0]  eligible;
    client_t     g;
    logic        grant;
    client_t     last_grant;
    lock_state_t lock_state;
    client_t     lock_owner;
    lock_cnt_t   lock_cnt;

    // A client may only issue when its response slot is free or draining now.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    rf_rr_lock_sel #(
        .LOCK_MAX (LOCK_MAX)
    ) u_sel (
        .eligible   (eligible),
        .last_grant (last_grant),
        .lock_state (lock_state),
        .lock_owner (lock_owner),
        .lock_cnt   (lock_cnt),
        .g          (g),
        .grant      (grant)
    );

    always_comb begin
        req_ready = '0;
        rf_WEN    = 1'b0;
        rf_wsel   = '0;
        rf_rsel1  = '0;
        rf_rsel2  = '0;
        rf_wdat   = '0;
        if (grant) begin
            req_ready[g] = 1'b1;
            rf_WEN       = req_wen[g];
            rf_wsel      = req_wsel[g];
            rf_rsel1     = req_rsel1[g];
            rf_rsel2     = req_rsel2[g];
            rf_wdat      = req_wdat[g];
        end
    end

    // Round-robin pointer and lock FSM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= 1'b1;
            lock_state <= UNLOCKED;
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            if (grant) begin
                last_grant <= g;
            end
            case (lock_state)
                UNLOCKED: begin
                    if (grant && req_lock[g]) begin
                        lock_state <= LOCKED;
                        lock_owner <= g;
                        lock_cnt   <= lock_cnt_t'(1);
                    end
                end
                LOCKED: begin
                    if (grant && req_lock[g]) begin
                        lock_owner <= g;
                        if (g != lock_owner) begin
                            lock_cnt <= lock_cnt_t'(1);
                        end else if (lock_cnt < LockMax) begin
                            lock_cnt <= lock_cnt + lock_cnt_t'(1);
                        end
                    end else if (grant || !eligible[lock_owner]) begin
                        lock_state <= UNLOCKED;
                        lock_cnt   <= '0;
                    end
                end
                default: begin
                    lock_state <= UNLOCKED;
                    lock_cnt   <= '0;
                end
            endcase
        end
    end

    // A new grant takes precedence over draining, so the slot reloads in place.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid <= '0;
            rsp_rdat1 <= '0;
            rsp_rdat2 <= '0;
        end else begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (grant && (g == client_t'(c))) begin
                    rsp_valid[c] <= 1'b1;
                    rsp_rdat1[c] <= rf_rdat1;
                    rsp_rdat2[c] <= rf_rdat2;
                end else if (rsp_ready[c]) begin
                    rsp_valid[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter with a behavioural register file.
module tb_rf_port_arbiter;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_wen;
    logic [1:0]       req_lock;
    logic [1:0][3:0]  req_wsel;
    logic [1:0][3:0]  req_rsel1;
    logic [1:0][3:0]  req_rsel2;
    logic [1:0][15:0] req_wdat;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][15:0] rsp_rdat1;
    logic [1:0][15:0] rsp_rdat2;
    logic             rf_WEN;
    logic [3:0]       rf_wsel;
    logic [3:0]       rf_rsel1;
    logic [3:0]       rf_rsel2;
    logic [15:0]      rf_wdat;
    logic [15:0]      rf_rdat1;
    logic [15:0]      rf_rdat2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf_mem [16];
    logic [15:0] shadow [16];
    logic [31:0] sb_q0 [$];
    logic [31:0] sb_q1 [$];
    logic [1:0]  exp_vld;
    logic [31:0] exp_dat [2];

    always #5 CLK = ~CLK;

    rf_port_arbiter #(
        .LOCK_MAX (4)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_lock  (req_lock),
        .req_wsel  (req_wsel),
        .req_rsel1 (req_rsel1),
        .req_rsel2 (req_rsel2),
        .req_wdat  (req_wdat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdat1 (rsp_rdat1),
        .rsp_rdat2 (rsp_rdat2),
        .rf_WEN    (rf_WEN),
        .rf_wsel   (rf_wsel),
        .rf_rsel1  (rf_rsel1),
        .rf_rsel2  (rf_rsel2),
        .rf_wdat   (rf_wdat),
        .rf_rdat1  (rf_rdat1),
        .rf_rdat2  (rf_rdat2)
    );

    // Register file: combinational read, write on the clock edge, no bypass.
    assign rf_rdat1 = rf_mem[rf_rsel1];
    assign rf_rdat2 = rf_mem[rf_rsel2];

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'(i * 16'h1111);
        forever begin
            @(posedge CLK);
            if (rf_WEN) rf_mem[rf_wsel] <= rf_wdat;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [1:0] wen,
                         input logic [1:0] lock, input logic [1:0] rdy);
        req_valid = valid;
        req_wen   = wen;
        req_lock  = lock;
        rsp_ready = rdy;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag, input logic [1:0] exp_ready);
        int          gi;
        logic [31:0] popped;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != 2'b00) begin
            gi = exp_ready[1] ? 1 : 0;
            check({tag, " rf mux"}, {3'b0, rf_WEN, rf_wsel, rf_rsel1, rf_rsel2, rf_wdat},
                  {3'b0, req_wen[gi], req_wsel[gi], req_rsel1[gi], req_rsel2[gi],
                   req_wdat[gi]});
            if (gi == 0) sb_q0.push_back({shadow[req_rsel1[0]], shadow[req_rsel2[0]]});
            else         sb_q1.push_back({shadow[req_rsel1[1]], shadow[req_rsel2[1]]});
            if (req_wen[gi]) shadow[req_wsel[gi]] = req_wdat[gi];
        end else begin
            check({tag, " rf idle"}, {3'b0, rf_WEN, rf_wsel, rf_rsel1, rf_rsel2, rf_wdat}, 32'h0);
        end
        @(posedge CLK);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (exp_ready[c]) begin
                if ((c == 0 && sb_q0.size() == 0) || (c == 1 && sb_q1.size() == 0)) begin
                    check($sformatf("%s sb empty %0d", tag, c), 32'h0, 32'h1);
                end else begin
                    if (c == 0) popped = sb_q0.pop_front();
                    else        popped = sb_q1.pop_front();
                    exp_dat[c] = popped;
                    exp_vld[c] = 1'b1;
                end
            end else if (rsp_ready[c]) begin
                exp_vld[c] = 1'b0;
            end
            check($sformatf("%s rsp_valid[%0d]", tag, c), 32'(rsp_valid[c]), 32'(exp_vld[c]));
            check($sformatf("%s rsp_rdat[%0d]", tag, c), {rsp_rdat1[c], rsp_rdat2[c]},
                  exp_dat[c]);
        end
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 16'(i * 16'h1111);
        exp_vld    = '0;
        exp_dat[0] = '0;
        exp_dat[1] = '0;
        nRST       = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        req_wsel  = '0;
        req_rsel1 = '0;
        req_rsel2 = '0;
        req_wdat  = '0;
        repeat (2) @(negedge CLK);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_rdat", {rsp_rdat1[0], rsp_rdat2[1]}, 32'h0);
        check("reset req_ready", 32'(req_ready), 32'h0);
        nRST = 1'b1;

        // Round-robin after reset: client 0 first, then alternate.
        drive(2'b11, 2'b11, 2'b00, 2'b11);
        req_wsel  = {4'd2, 4'd1};
        req_wdat  = {16'h2000, 16'h1000};
        req_rsel1 = {4'd1, 4'd2};
        req_rsel2 = {4'd3, 4'd4};
        step("rr0", 2'b01);
        step("rr1", 2'b10);
        step("rr2", 2'b01);
        step("rr3", 2'b10);

        // Write r5, read it back, then same-cycle write/read returns old data.
        drive(2'b01, 2'b01, 2'b00, 2'b11);
        req_wsel[0]  = 4'd5;
        req_wdat[0]  = 16'hBEEF;
        req_rsel1[0] = 4'd0;
        req_rsel2[0] = 4'd1;
        step("wr r5", 2'b01);
        req_wen      = 2'b00;
        req_rsel1[0] = 4'd5;
        step("rd r5", 2'b01);
        check("rd r5 beef", 32'(rsp_rdat1[0]), 32'h0000BEEF);
        req_wen     = 2'b01;
        req_wdat[0] = 16'h1234;
        step("rdw r5", 2'b01);
        check("rdw old value", 32'(rsp_rdat1[0]), 32'h0000BEEF);
        req_wen = 2'b00;
        step("rd r5 new", 2'b01);
        check("rd r5 1234", 32'(rsp_rdat1[0]), 32'h00001234);

        // Lock: client 1 holds four grants, then client 0 gets one.
        drive(2'b11, 2'b00, 2'b10, 2'b11);
        req_rsel1 = {4'd5, 4'd2};
        req_rsel2 = {4'd1, 4'd3};
        for (int i = 0; i < 4; i++) step($sformatf("lock%0d", i), 2'b10);
        step("lock release", 2'b01);
        step("relock", 2'b10);
        req_lock = 2'b00;
        step("lock drop", 2'b10);
        step("after drop", 2'b01);

        // Backpressure on client 0.
        drive(2'b00, 2'b00, 2'b00, 2'b10);
        step("drain c1", 2'b00);
        drive(2'b11, 2'b00, 2'b00, 2'b00);
        step("bp c1 wins", 2'b10);
        drive(2'b01, 2'b00, 2'b00, 2'b00);
        step("bp c0 stall", 2'b00);
        rsp_ready = 2'b01;
        step("bp c0 ready", 2'b01);

        // Idle: nothing moves, data held.
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i), 2'b00);
        drive(2'b11, 2'b00, 2'b00, 2'b11);
        step("idle exit", 2'b10);

        // Build LOCKED(owner 1) with both responses pending, then reset mid-cycle.
        drive(2'b11, 2'b00, 2'b10, 2'b10);
        step("pre rst c0", 2'b01);
        step("pre rst c1 lock", 2'b10);
        check("pre rst valid", 32'(rsp_valid), 32'h3);
        #2;
        nRST = 1'b0;
        #1;
        exp_vld    = '0;
        exp_dat[0] = '0;
        exp_dat[1] = '0;
        check("async rst valid", 32'(rsp_valid), 32'h0);
        check("async rst data", {rsp_rdat1[1], rsp_rdat2[0]}, 32'h0);
        @(posedge CLK);
        #1;
        check("rst cycle grant ignored", 32'(rsp_valid), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 2'b11);
        step("post rst c0", 2'b01);
        step("post rst c1", 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
